// File: rtl/_universal_register.sv
// WIDTH-bit universal register: hold, load, shift/rotate steps,
// serial in/out, and a multi-cycle shift-by-N with busy/done.
module _universal_register #(
  parameter int               WIDTH       = 8,
  parameter int               AMT_W       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       op;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             op_shift;

  // While running, the latched mode drives the step, not the live input.
  assign op = (state_q == RUN) ? mode_q : mode;

  always_comb begin
    step_q    = q_q;
    step_sout = sout_q;
    op_shift  = 1'b1;
    unique case (op)
      M_SHL: begin
        step_q    = {q_q[WIDTH-2:0], sin};
        step_sout = q_q[WIDTH-1];
      end
      M_SHR: begin
        step_q    = {sin, q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      M_ROL: begin
        step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_sout = q_q[WIDTH-1];
      end
      M_ROR: begin
        step_q    = {q_q[0], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      M_ASR: begin
        step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      default: op_shift = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          q_d    = RESET_VALUE;
          sout_d = 1'b0;
        end else if (start && op_shift) begin
          if (amt != '0) begin
            mode_d  = mode;
            cnt_d   = amt;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          if (op_shift) begin
            q_d    = step_q;
            sout_d = step_sout;
          end else if (mode == M_LOAD) begin
            q_d = d;
          end
        end
      end
      RUN: begin
        if (clr) begin
          q_d     = RESET_VALUE;
          sout_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          q_d    = step_q;
          sout_d = step_sout;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= RESET_VALUE;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb__universal_register.sv
// Bench for _universal_register: directed scenarios plus random
// stimulus against a cycle-level arithmetic reference model.
module tb__universal_register;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'd0;
  logic       sin = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amt = 4'd0;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  int m_q = 0, m_sout = 0, m_busy = 0, m_done = 0;
  int m_left = 0, m_mode = 0;

  _universal_register #(
    .WIDTH(8),
    .AMT_W(4),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .en(en),
    .mode(mode),
    .d(d),
    .sin(sin),
    .start(start),
    .amt(amt),
    .q(q),
    .sout(sout),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int md, input int sb,
                            inout int mq, inout int ms);
    case (md)
      2: begin ms = (mq >> 7) & 1; mq = ((mq << 1) | sb) & 255; end
      3: begin ms = mq & 1; mq = (mq >> 1) | (sb << 7); end
      4: begin ms = (mq >> 7) & 1; mq = ((mq << 1) | ms) & 255; end
      5: begin ms = mq & 1; mq = (mq >> 1) | (ms << 7); end
      6: begin ms = mq & 1; mq = (mq >> 1) | (mq & 128); end
      default: ;
    endcase
  endtask

  task automatic drive(input bit c, input bit e, input int md,
                       input int dd, input bit s, input bit st,
                       input int a);
    clr   = c;
    en    = e;
    mode  = 3'(md);
    d     = 8'(dd);
    sin   = s;
    start = st;
    amt   = 4'(a);
  endtask

  // Advance model by one edge using current inputs, then compare.
  task automatic tick();
    bit is_shift;
    is_shift = (mode >= 3'd2) && (mode <= 3'd6);
    m_done = 0;
    if (m_busy == 0) begin
      if (clr) begin
        m_q = 0;
        m_sout = 0;
      end else if (start && is_shift) begin
        if (amt != 0) begin
          m_busy = 1;
          m_left = int'(amt);
          m_mode = int'(mode);
        end else begin
          m_done = 1;
        end
      end else if (en) begin
        if (mode == 3'd1) m_q = int'(d);
        else model_step(int'(mode), int'(sin), m_q, m_sout);
      end
    end else begin
      if (clr) begin
        m_q = 0;
        m_sout = 0;
        m_busy = 0;
      end else begin
        model_step(m_mode, int'(sin), m_q, m_sout);
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("q", int'(q), m_q);
    chk("sout", int'(sout), m_sout);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_left = 0;
    chk({tag, "_q"}, int'(q), 0);
    chk({tag, "_sout"}, int'(sout), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset("rst0");

    // Async reset mid-run
    drive(0, 1, 1, 'h5A, 0, 0, 0); tick();
    drive(0, 0, 4, 0, 0, 1, 5); tick();
    chk("t1_busy", int'(busy), 1);
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    do_reset("t1_rst");

    // Single steps
    drive(0, 1, 1, 'hA5, 0, 0, 0); tick();
    drive(0, 1, 2, 0, 1, 0, 0); tick();
    chk("t2_shl", int'(q), 'h4B);
    chk("t2_shl_sout", int'(sout), 1);
    drive(0, 1, 3, 0, 0, 0, 0); tick();
    chk("t2_shr", int'(q), 'h25);
    chk("t2_shr_sout", int'(sout), 1);
    drive(0, 0, 1, 'hFF, 1, 0, 0);
    repeat (3) tick();
    chk("t2_hold", int'(q), 'h25);

    drive(0, 1, 1, 'h80, 0, 0, 0); tick();
    drive(0, 1, 6, 0, 1, 0, 0); tick();
    chk("t3_asr", int'(q), 'hC0);
    chk("t3_asr_sout", int'(sout), 0);
    drive(0, 1, 1, 'h01, 0, 0, 0); tick();
    drive(0, 1, 5, 0, 0, 0, 0); tick();
    chk("t3_ror", int'(q), 'h80);
    chk("t3_ror_sout", int'(sout), 1);
    drive(0, 1, 7, 'h33, 1, 0, 0); tick();
    chk("t3_m7", int'(q), 'h80);

    // Multi-shift, inputs changing while busy
    drive(0, 1, 1, 'h81, 0, 0, 0); tick();
    drive(0, 0, 4, 0, 0, 1, 3); tick();
    chk("t4_busy0", int'(busy), 1);
    drive(0, 1, 1, 'hFF, 1, 0, 9); tick();
    chk("t4_busy1", int'(busy), 1);
    drive(0, 1, 2, 'h11, 0, 0, 2); tick();
    chk("t4_busy2", int'(busy), 1);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t4_q", int'(q), 'h0C);
    chk("t4_sout", int'(sout), 0);
    chk("t4_done", int'(done), 1);
    chk("t4_busy3", int'(busy), 0);
    tick();
    chk("t4_done_off", int'(done), 0);

    // amt==0, start while busy, start on done cycle
    drive(0, 0, 2, 0, 1, 1, 0); tick();
    chk("t5_z_done", int'(done), 1);
    chk("t5_z_busy", int'(busy), 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 5, 0, 0, 1, 4); tick();
    drive(0, 0, 2, 0, 1, 1, 1);
    repeat (3) tick();
    chk("t5_still_busy", int'(busy), 1);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t5_done", int'(done), 1);
    drive(0, 0, 4, 0, 0, 1, 2); tick();
    chk("t5_restart", int'(busy), 1);
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    chk("t5_done2", int'(done), 1);

    // Abort and long ASR
    drive(0, 1, 1, 'hFF, 0, 0, 0); tick();
    drive(0, 0, 3, 0, 0, 1, 6); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    chk("t6_clr_q", int'(q), 0);
    chk("t6_clr_busy", int'(busy), 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("t6_no_done", int'(done), 0);
    drive(0, 1, 1, 'h80, 0, 0, 0); tick();
    drive(0, 0, 6, 0, 0, 1, 12); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (12) tick();
    chk("t6_asr_q", int'(q), 'hFF);
    chk("t6_asr_done", int'(done), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 15)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
